// File: rtl/mcc_data_parse_pkg.sv
// -----------------------------------------------------------------------------
// mcc_data_parse_pkg
//
// Receive-side parser for MCC messages. Once a UDP datagram payload sits in the
// rx payload RAM, this block reads it back one 32-bit word at a time, checks
// the 16-byte header, and (for a command) forwards the payload words. Each
// packet produces exactly one single-cycle response request: ack, nack or
// status-request with a 3-bit option code.
//
// Header words: 0 = payload byte length (header excluded), 1 = sequence,
//               2 = reserved, 3 = message ID, 4.. = payload.
//
// Ports
//   i_sys_clk                  system clock, rising edge
//   i_rst_n                    asynchronous active-low reset
//   i_rx_pkg_done              1-cycle pulse: datagram is in the rx RAM
//   i_rx_pkg_length            datagram byte count, valid with done
//   o_ram_rd_en/o_ram_rd_addr  rx RAM read port (address held when idle)
//   i_ram_rd_data              rx RAM data, 1 cycle after the read enable
//   o_cmd_wr_en/addr/data      command payload word strobe, index and word
//   o_cmd_valid                1-cycle pulse: full command forwarded
//   o_req_ack_start_en         1-cycle ack request
//   o_req_nack_start_en        1-cycle nack request
//   o_status_request_start_en  1-cycle status request
//   o_status_request_data      status option, held until the next status pulse
//   o_parse_busy               a packet is being processed
//   o_last_seq                 sequence of the last header that passed checks
//   o_rx_pkg_cnt               acked/status packets (saturating)
//   o_rx_err_cnt               nacked packets (saturating)
//   o_rx_overrun               1-cycle pulse: done arrived while busy (dropped)
// -----------------------------------------------------------------------------
module mcc_data_parse_pkg #(
    parameter int RAM_AW            = 9,
    parameter int CMD_WORDS         = 6,
    parameter int MSG_ID_STATUS_REQ = 100,
    parameter int MSG_ID_COMMAND    = 101,
    parameter int MAX_PAYLOAD_BYTES = 256
) (
    input  logic              i_sys_clk,
    input  logic              i_rst_n,
    input  logic              i_rx_pkg_done,
    input  logic [15:0]       i_rx_pkg_length,
    output logic              o_ram_rd_en,
    output logic [RAM_AW-1:0] o_ram_rd_addr,
    input  logic [31:0]       i_ram_rd_data,
    output logic              o_cmd_wr_en,
    output logic [7:0]        o_cmd_wr_addr,
    output logic [31:0]       o_cmd_wr_data,
    output logic              o_cmd_valid,
    output logic              o_req_ack_start_en,
    output logic              o_req_nack_start_en,
    output logic              o_status_request_start_en,
    output logic [2:0]        o_status_request_data,
    output logic              o_parse_busy,
    output logic [31:0]       o_last_seq,
    output logic [15:0]       o_rx_pkg_cnt,
    output logic [15:0]       o_rx_err_cnt,
    output logic              o_rx_overrun
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_HDR,
        S_CHECK,
        S_RD_PAYLOAD,
        S_RESP,
        S_DONE
    } state_t;

    state_t              r_state;
    state_t              w_next;

    logic [2:0]          r_hdr_cnt;     // RD_HDR step: 0..3 issue reads, 4 captures word3
    logic [7:0]          r_issue;       // payload reads issued so far
    logic [15:0]         r_rx_len;
    logic                r_err;
    logic                r_rd_vld;      // read data is on i_ram_rd_data this cycle
    logic [7:0]          r_rd_idx;      // header or payload index of that data
    logic [RAM_AW-1:0]   r_addr_hold;
    logic [31:0]         r_last_seq;
    logic [15:0]         r_pkg_cnt;
    logic [15:0]         r_err_cnt;
    logic                r_overrun;
    logic [2:0]          r_status_data;

    logic [31:0]         r_word0;
    logic [31:0]         r_seq;
    logic [31:0]         r_msg_id;

    logic                w_rd_en;
    logic [RAM_AW-1:0]   w_rd_addr;
    logic [7:0]          w_rd_idx;
    logic                w_is_status;
    logic                w_is_cmd;
    logic [16:0]         w_len_sum;
    logic [7:0]          w_pay_words;
    logic                w_bad;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Header decode, evaluated during CHECK from the captured words.
    assign w_is_status = (r_msg_id == 32'(MSG_ID_STATUS_REQ));
    assign w_is_cmd    = (r_msg_id == 32'(MSG_ID_COMMAND));
    // Only the low 16 bits take part in the sum; anything larger is already
    // rejected by the MAX_PAYLOAD_BYTES bound, so the 17-bit sum never wraps.
    assign w_len_sum   = {1'b0, r_word0[15:0]} + 17'd16;
    assign w_pay_words = {1'b0, r_word0[8:2]};

    assign w_bad = (r_word0[1:0] != 2'b00)
                || (r_word0 > 32'(MAX_PAYLOAD_BYTES))
                || ({1'b0, r_rx_len} != w_len_sum)
                || (!w_is_status && !w_is_cmd)
                || (w_is_status && (r_word0 != 32'd4))
                || (w_is_cmd && (r_word0 != 32'(4 * CMD_WORDS)));

    // ---- next state and combinational outputs ----
    always_comb begin
        w_next                    = r_state;
        w_rd_en                   = 1'b0;
        w_rd_addr                 = r_addr_hold;
        w_rd_idx                  = r_rd_idx;
        o_cmd_wr_en               = 1'b0;
        o_cmd_wr_addr             = 8'd0;
        o_cmd_wr_data             = 32'd0;
        o_cmd_valid               = 1'b0;
        o_req_ack_start_en        = 1'b0;
        o_req_nack_start_en       = 1'b0;
        o_status_request_start_en = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (i_rx_pkg_done) begin
                    w_next = S_RD_HDR;
                end
            end
            S_RD_HDR: begin
                if (r_hdr_cnt < 3'd4) begin
                    w_rd_en   = 1'b1;
                    w_rd_addr = RAM_AW'(r_hdr_cnt);
                    w_rd_idx  = 8'(r_hdr_cnt);
                end else begin
                    w_next = S_CHECK;
                end
            end
            S_CHECK: begin
                if (w_bad) begin
                    w_next = S_RESP;
                end else begin
                    // First payload read is issued here so the response lands
                    // 7+P cycles after done.
                    w_rd_en   = 1'b1;
                    w_rd_addr = RAM_AW'(4) + RAM_AW'(r_issue);
                    w_rd_idx  = r_issue;
                    w_next    = S_RD_PAYLOAD;
                end
            end
            S_RD_PAYLOAD: begin
                if (r_issue < w_pay_words) begin
                    w_rd_en   = 1'b1;
                    w_rd_addr = RAM_AW'(4) + RAM_AW'(r_issue);
                    w_rd_idx  = r_issue;
                end
                if (r_rd_vld) begin
                    if (w_is_cmd) begin
                        o_cmd_wr_en   = 1'b1;
                        o_cmd_wr_addr = r_rd_idx;
                        o_cmd_wr_data = i_ram_rd_data;
                    end
                    if (r_rd_idx == w_pay_words - 8'd1) begin
                        w_next = S_RESP;
                    end
                end
            end
            S_RESP: begin
                if (r_err) begin
                    o_req_nack_start_en = 1'b1;
                end else if (w_is_status) begin
                    o_status_request_start_en = 1'b1;
                end else begin
                    o_req_ack_start_en = 1'b1;
                    o_cmd_valid        = 1'b1;
                end
                w_next = S_DONE;
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    assign o_ram_rd_en           = w_rd_en;
    assign o_ram_rd_addr         = w_rd_addr;
    assign o_parse_busy          = (r_state != S_IDLE);
    assign o_last_seq            = r_last_seq;
    assign o_rx_pkg_cnt          = r_pkg_cnt;
    assign o_rx_err_cnt          = r_err_cnt;
    assign o_rx_overrun          = r_overrun;
    assign o_status_request_data = r_status_data;

    // ---- state register and control ----
    always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= S_IDLE;
            r_hdr_cnt     <= 3'd0;
            r_issue       <= 8'd0;
            r_rx_len      <= 16'd0;
            r_err         <= 1'b0;
            r_rd_vld      <= 1'b0;
            r_rd_idx      <= 8'd0;
            r_addr_hold   <= '0;
            r_last_seq    <= 32'd0;
            r_pkg_cnt     <= 16'd0;
            r_err_cnt     <= 16'd0;
            r_overrun     <= 1'b0;
            r_status_data <= 3'd0;
        end else begin
            r_state   <= w_next;
            r_rd_vld  <= w_rd_en;
            r_overrun <= i_rx_pkg_done && (r_state != S_IDLE);
            if (w_rd_en) begin
                r_rd_idx    <= w_rd_idx;
                r_addr_hold <= w_rd_addr;
            end

            case (r_state)
                S_IDLE: begin
                    if (i_rx_pkg_done) begin
                        r_rx_len  <= i_rx_pkg_length;
                        r_hdr_cnt <= 3'd0;
                        r_issue   <= 8'd0;
                        r_err     <= 1'b0;
                    end
                end
                S_RD_HDR: begin
                    r_hdr_cnt <= r_hdr_cnt + 3'd1;
                end
                S_CHECK: begin
                    r_err <= w_bad;
                    if (!w_bad) begin
                        r_last_seq <= r_seq;
                        r_issue    <= r_issue + 8'd1;
                    end
                end
                S_RD_PAYLOAD: begin
                    if (w_rd_en) begin
                        r_issue <= r_issue + 8'd1;
                    end
                    // A status option word may only use its low 3 bits; the
                    // option register changes only for a good status packet.
                    if (r_rd_vld && w_is_status) begin
                        if (|i_ram_rd_data[31:3]) begin
                            r_err <= 1'b1;
                        end else begin
                            r_status_data <= i_ram_rd_data[2:0];
                        end
                    end
                end
                S_RESP: begin
                    if (r_err) begin
                        r_err_cnt <= sat_inc16(r_err_cnt);
                    end else begin
                        r_pkg_cnt <= sat_inc16(r_pkg_cnt);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // ---- header word capture (data only, no reset) ----
    always_ff @(posedge i_sys_clk) begin
        if ((r_state == S_RD_HDR) && r_rd_vld) begin
            case (r_rd_idx[1:0])
                2'd0:    r_word0  <= i_ram_rd_data;
                2'd1:    r_seq    <= i_ram_rd_data;
                2'd3:    r_msg_id <= i_ram_rd_data;
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mcc_data_parse_pkg.sv
module tb_mcc_data_parse_pkg;

    localparam int RAM_AW = 9;
    localparam int K_ACK  = 0;
    localparam int K_NACK = 1;
    localparam int K_STAT = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              i_rx_pkg_done = 1'b0;
    logic [15:0]       i_rx_pkg_length = 16'd0;
    logic              o_ram_rd_en;
    logic [RAM_AW-1:0] o_ram_rd_addr;
    logic [31:0]       i_ram_rd_data = 32'd0;
    logic              o_cmd_wr_en;
    logic [7:0]        o_cmd_wr_addr;
    logic [31:0]       o_cmd_wr_data;
    logic              o_cmd_valid;
    logic              o_req_ack_start_en;
    logic              o_req_nack_start_en;
    logic              o_status_request_start_en;
    logic [2:0]        o_status_request_data;
    logic              o_parse_busy;
    logic [31:0]       o_last_seq;
    logic [15:0]       o_rx_pkg_cnt;
    logic [15:0]       o_rx_err_cnt;
    logic              o_rx_overrun;

    mcc_data_parse_pkg dut (
        .i_sys_clk                 (clk),
        .i_rst_n                   (rst_n),
        .i_rx_pkg_done             (i_rx_pkg_done),
        .i_rx_pkg_length           (i_rx_pkg_length),
        .o_ram_rd_en               (o_ram_rd_en),
        .o_ram_rd_addr             (o_ram_rd_addr),
        .i_ram_rd_data             (i_ram_rd_data),
        .o_cmd_wr_en               (o_cmd_wr_en),
        .o_cmd_wr_addr             (o_cmd_wr_addr),
        .o_cmd_wr_data             (o_cmd_wr_data),
        .o_cmd_valid               (o_cmd_valid),
        .o_req_ack_start_en        (o_req_ack_start_en),
        .o_req_nack_start_en       (o_req_nack_start_en),
        .o_status_request_start_en (o_status_request_start_en),
        .o_status_request_data     (o_status_request_data),
        .o_parse_busy              (o_parse_busy),
        .o_last_seq                (o_last_seq),
        .o_rx_pkg_cnt              (o_rx_pkg_cnt),
        .o_rx_err_cnt              (o_rx_err_cnt),
        .o_rx_overrun              (o_rx_overrun)
    );

    always #5 clk = ~clk;

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // rx payload RAM model: data one cycle after the read enable
    logic [31:0] mem [0:511];
    always @(posedge clk) begin
        if (o_ram_rd_en) i_ram_rd_data <= mem[o_ram_rd_addr];
    end

    typedef struct {int kind; int opt; longint cyc;} resp_t;
    typedef struct {int idx; logic [31:0] data;} cmd_t;

    resp_t  resp_q[$];
    cmd_t   cmd_q[$];
    int     addr_q[$];
    longint ovr_q[$];

    int n_cmp  = 0;
    int n_fail = 0;

    int          m_pkg = 0;
    int          m_err = 0;
    logic [31:0] m_seq = 32'd0;
    logic [31:0] pay [6];

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: rules applied directly to the header fields.
    function automatic void ref_model(input logic [15:0] len, input logic [31:0] w0,
                                      input logic [31:0] id, input logic [31:0] optw,
                                      output int kind, output int opt, output int p,
                                      output bit hdr_ok);
        longint lw0;
        lw0    = longint'(w0);
        hdr_ok = 1'b1;
        opt    = 0;
        if (lw0 % 4 != 0) hdr_ok = 1'b0;
        if (lw0 > 256) hdr_ok = 1'b0;
        if (longint'(len) != lw0 + 16) hdr_ok = 1'b0;
        if (id != 100 && id != 101) hdr_ok = 1'b0;
        if (id == 100 && lw0 != 4) hdr_ok = 1'b0;
        if (id == 101 && lw0 != 24) hdr_ok = 1'b0;
        if (!hdr_ok) begin
            kind = K_NACK;
            p    = 0;
        end else if (id == 100) begin
            p = 1;
            if (optw > 7) kind = K_NACK;
            else begin
                kind = K_STAT;
                opt  = int'(optw);
            end
        end else begin
            p    = 6;
            kind = K_ACK;
        end
    endfunction

    // Monitor: pops expectations whenever the DUT presents an output event.
    always @(negedge clk) begin
        int np;
        int k;
        resp_t e;
        cmd_t c;
        if (rst_n) begin
            if (o_ram_rd_en) begin
                if (addr_q.size() == 0) chk("unexpected_read", longint'(o_ram_rd_addr), -1);
                else chk("rd_addr", longint'(o_ram_rd_addr), longint'(addr_q.pop_front()));
            end
            if (o_cmd_wr_en) begin
                if (cmd_q.size() == 0) chk("unexpected_cmd_wr", longint'(o_cmd_wr_addr), -1);
                else begin
                    c = cmd_q.pop_front();
                    chk("cmd_wr_addr", longint'(o_cmd_wr_addr), longint'(c.idx));
                    chk("cmd_wr_data", longint'(o_cmd_wr_data), longint'(c.data));
                end
            end
            np = int'(o_req_ack_start_en) + int'(o_req_nack_start_en) + int'(o_status_request_start_en);
            if (np > 0) begin
                chk("one_resp_pulse", np, 1);
                k = o_req_ack_start_en ? K_ACK : (o_req_nack_start_en ? K_NACK : K_STAT);
                if (resp_q.size() == 0) chk("unexpected_resp", k, -1);
                else begin
                    e = resp_q.pop_front();
                    chk("resp_kind", k, e.kind);
                    chk("resp_cycle", cyc, e.cyc);
                    chk("cmd_valid_with_ack", longint'(o_cmd_valid), longint'(e.kind == K_ACK));
                    if (e.kind == K_STAT) chk("status_data", longint'(o_status_request_data), e.opt);
                end
            end else if (o_cmd_valid) begin
                chk("cmd_valid_alone", 1, 0);
            end
            if (o_rx_overrun) begin
                if (ovr_q.size() == 0) chk("unexpected_overrun", cyc, -1);
                else chk("overrun_cycle", cyc, ovr_q.pop_front());
            end
        end
    end

    task automatic start_pkt(input logic [15:0] len, input logic [31:0] w0, input logic [31:0] w1,
                             input logic [31:0] id, input bit track);
        int kind, opt, p;
        bit hok;
        longint t;
        mem[0] = w0;
        mem[1] = w1;
        mem[2] = $urandom;
        mem[3] = id;
        for (int i = 0; i < 6; i++) mem[4 + i] = pay[i];
        ref_model(len, w0, id, pay[0], kind, opt, p, hok);
        @(posedge clk);
        #1;
        t = cyc;
        for (int a = 0; a < 4 + p; a++) addr_q.push_back(a);
        if (kind == K_ACK) for (int i = 0; i < 6; i++) cmd_q.push_back('{i, pay[i]});
        if (track) begin
            resp_q.push_back('{kind, opt, t + 7 + longint'(p)});
            if (hok) m_seq = w1;
            if (kind == K_NACK) begin
                if (m_err < 65535) m_err++;
            end else begin
                if (m_pkg < 65535) m_pkg++;
            end
        end
        i_rx_pkg_done   = 1'b1;
        i_rx_pkg_length = len;
        @(posedge clk);
        #1;
        i_rx_pkg_done   = 1'b0;
        i_rx_pkg_length = 16'($urandom);
    endtask

    task automatic wait_pkt(input string tag);
        int k;
        for (k = 0; k < 200; k++) begin
            @(negedge clk);
            if (!o_parse_busy) break;
        end
        chk({tag, "_busy_timeout"}, longint'(k < 200), 1);
        chk({tag, "_resp_pending"}, resp_q.size(), 0);
        chk({tag, "_cmd_pending"}, cmd_q.size(), 0);
        chk({tag, "_pkg_cnt"}, longint'(o_rx_pkg_cnt), m_pkg);
        chk({tag, "_err_cnt"}, longint'(o_rx_err_cnt), m_err);
        chk({tag, "_last_seq"}, longint'(o_last_seq), longint'(m_seq));
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_ctrl"}, longint'({o_ram_rd_en, o_ram_rd_addr, o_cmd_wr_en, o_cmd_wr_addr,
                                      o_cmd_valid, o_req_ack_start_en, o_req_nack_start_en,
                                      o_status_request_start_en, o_status_request_data,
                                      o_parse_busy, o_rx_overrun}), 0);
        chk({tag, "_wr_data"}, longint'(o_cmd_wr_data), 0);
        chk({tag, "_seq"}, longint'(o_last_seq), 0);
        chk({tag, "_cnts"}, longint'({o_rx_pkg_cnt, o_rx_err_cnt}), 0);
    endtask

    initial begin
        logic [31:0] w0, id;
        logic [15:0] len;
        longint t2;
        int sel;

        for (int i = 0; i < 512; i++) mem[i] = 32'd0;
        for (int i = 0; i < 6; i++) pay[i] = 32'd0;

        // reset state
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        @(posedge clk);
        #1 rst_n = 1'b1;

        // status request, option 3
        pay[0] = 32'd3;
        start_pkt(16'd20, 32'd4, 32'h55, 32'd100, 1'b1);
        wait_pkt("status");

        // command with six payload words
        for (int i = 0; i < 6; i++) pay[i] = 32'hA0 + 32'(i);
        start_pkt(16'd40, 32'd24, 32'h1234_5678, 32'd101, 1'b1);
        wait_pkt("command");

        // length mismatch
        pay[0] = 32'd1;
        start_pkt(16'd24, 32'd4, 32'hDEAD, 32'd100, 1'b1);
        wait_pkt("len_mismatch");

        // unknown ID
        start_pkt(16'd20, 32'd4, 32'h77, 32'd7, 1'b1);
        wait_pkt("unknown_id");

        // bad status option word
        pay[0] = 32'h0000_0008;
        start_pkt(16'd20, 32'd4, 32'h88, 32'd100, 1'b1);
        wait_pkt("bad_option");

        // word0 beyond 16 bits must not alias to a matching length
        pay[0] = 32'd2;
        start_pkt(16'd20, 32'h0001_0004, 32'h99, 32'd100, 1'b1);
        wait_pkt("wide_word0");

        // overrun: second done three cycles after the first
        pay[0] = 32'd5;
        start_pkt(16'd20, 32'd4, 32'hAB, 32'd100, 1'b1);
        @(posedge clk);
        @(posedge clk);
        #1;
        t2 = cyc;
        ovr_q.push_back(t2 + 1);
        i_rx_pkg_done   = 1'b1;
        i_rx_pkg_length = 16'd40;
        @(posedge clk);
        #1 i_rx_pkg_done = 1'b0;
        wait_pkt("overrun");
        chk("overrun_pending", ovr_q.size(), 0);

        // reset during command payload read
        for (int i = 0; i < 6; i++) pay[i] = $urandom;
        start_pkt(16'd40, 32'd24, 32'hCAFE, 32'd101, 1'b0);
        repeat (8) @(posedge clk);
        #1 rst_n = 1'b0;
        chk("cmd_writes_before_reset", cmd_q.size(), 4);
        @(negedge clk);
        check_all_zero("midreset");
        addr_q.delete();
        cmd_q.delete();
        m_pkg = 0;
        m_err = 0;
        m_seq = 32'd0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        pay[0] = 32'd6;
        start_pkt(16'd20, 32'd4, 32'h4242, 32'd100, 1'b1);
        wait_pkt("after_reset");

        // randomized packets
        for (int n = 0; n < 30; n++) begin
            for (int i = 0; i < 6; i++) pay[i] = $urandom;
            sel = $urandom_range(0, 6);
            id  = 32'd100;
            case (sel)
                0: begin w0 = 32'd4;  len = 16'd20; pay[0] = 32'($urandom_range(0, 7)); end
                1: begin w0 = 32'd4;  len = 16'd20; pay[0] = {29'($urandom_range(1, 1000)), 3'($urandom)}; end
                2: begin w0 = 32'd24; len = 16'd40; id = 32'd101; end
                3: begin
                    w0  = ($urandom_range(0, 1) != 0) ? 32'd24 : 32'd4;
                    id  = (w0 == 32'd24) ? 32'd101 : 32'd100;
                    len = 16'($urandom);
                    if (len == 16'(w0 + 32'd16)) len = len + 16'd4;
                end
                4: begin
                    w0 = 32'd4; len = 16'd20;
                    id = $urandom;
                    if (id == 32'd100 || id == 32'd101) id = 32'd102;
                end
                5: begin w0 = 32'd24 + 32'($urandom_range(1, 3)); len = 16'(w0 + 32'd16); id = 32'd101; end
                default: begin w0 = 32'($urandom_range(257, 2000)); len = 16'(w0 + 32'd16); end
            endcase
            start_pkt(len, w0, $urandom, id, 1'b1);
            wait_pkt("random");
        end

        chk("final_addr_pending", addr_q.size(), 0);
        chk("final_ovr_pending", ovr_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
